tile_fetch_agu: RTL and testbench

Parametrised 2-D tile fetch address generator for the on-chip BRAM buffers (W/b/I/Q/K/V). It issues one BRAM read address per cycle from a latched descriptor (base, inner count/stride, outer count/stride). One engine therefore covers linear tile fetches and transposed (column-strided) fetches. It adds downstream back-pressure, BRAM-latency-aligned valid/last sideband, and abort, and sits between the arbiter control FSM and the BRAM read port.

---
 rtl/tile_fetch_agu_pkg.sv | 23 ++
 rtl/tile_fetch_agu_valid_pipe.sv | 39 +++
 rtl/tile_fetch_agu.sv | 219 +++++++++++++++++++++
 tb/tb_tile_fetch_agu.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_fetch_agu_pkg.sv
// Shared definitions for the tile fetch address generator: FSM encoding,
// default geometry and the on-chip buffer base-address map.
package tile_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_CNT_WIDTH  = 10;
   localparam int DEF_RD_LATENCY = 2;

   // Buffer region bases inside the shared BRAM address space
   localparam logic [15:0] BUF_W_BASE = 16'd0;
   localparam logic [15:0] BUF_B_BASE = 16'd64;
   localparam logic [15:0] BUF_I_BASE = 16'd112;
   localparam logic [15:0] BUF_K_BASE = 16'd2048;
   localparam logic [15:0] BUF_V_BASE = 16'd4096;

endpackage

// File: rtl/tile_fetch_agu_valid_pipe.sv
// Delay line carrying {valid, last} alongside BRAM read latency; a flush
// drops every in-flight entry.
module fetch_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last
);

   logic [DEPTH-1:0] valid_r;
   logic [DEPTH-1:0] last_r;

   // Shift stage registers; last is only kept together with valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {DEPTH{1'b0}};
         last_r  <= {DEPTH{1'b0}};
      end else if (flush) begin
         valid_r <= {DEPTH{1'b0}};
         last_r  <= {DEPTH{1'b0}};
      end else begin
         valid_r[0] <= in_valid;
         last_r[0]  <= in_valid & in_last;
         for (int i = 1; i < DEPTH; i++) begin
            valid_r[i] <= valid_r[i-1];
            last_r[i]  <= last_r[i-1];
         end
      end
   end

   assign out_valid = valid_r[DEPTH-1];
   assign out_last  = last_r[DEPTH-1];

endmodule

// File: rtl/tile_fetch_agu.sv
// 2-D tile fetch address generator: one BRAM read per cycle from a latched
// descriptor. Optional overflow flag built with TILE_FETCH_AGU_BOUNDS_CHECK_EN.
module tile_fetch_agu
   import tile_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] desc_base,
   input  logic [CNT_WIDTH-1:0]  desc_inner_cnt,
   input  logic [ADDR_WIDTH-1:0] desc_inner_stride,
   input  logic [CNT_WIDTH-1:0]  desc_outer_cnt,
   input  logic [ADDR_WIDTH-1:0] desc_outer_stride,
   input  logic                  issue_ready,
   output logic                  bram_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  busy,
   output logic                  fetch_done,
   output logic                  addr_err
);

`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
   localparam int SUM_W = ADDR_WIDTH + 1;
`else
   localparam int SUM_W = ADDR_WIDTH;
`endif
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

   fetch_state_e          state_r, state_s;
   logic [ADDR_WIDTH-1:0] addr_r, row_r, istride_r, ostride_r, bram_addr_r;
   logic [CNT_WIDTH-1:0]  icnt_r, ocnt_r, in_r, out_r;
   logic                  bram_en_r, last_r, busy_r, done_r;

   logic [ADDR_WIDTH-1:0] cur_addr_s, cur_row_s, cur_istride_s, cur_ostride_s;
   logic [CNT_WIDTH-1:0]  cur_in_s, cur_out_s, cur_icnt_s, cur_ocnt_s;
   logic [ADDR_WIDTH-1:0] addr_n_s, row_n_s;
   logic [CNT_WIDTH-1:0]  in_n_s, out_n_s;
   logic [SUM_W-1:0]      sum_inner_s, sum_outer_s;
   logic                  idle_s, accept_s, zero_s, fire_s, end_row_s, final_s;
   logic                  pipe_valid_s, pipe_last_s, flush_s;
`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
   logic                  carry_s;
   logic                  err_r;
`endif

   // Issue decision, address stepping and next-state selection
   always_comb begin
      idle_s = (state_r == ST_IDLE);
      // In IDLE the descriptor inputs stand in for the not-yet-latched copy
      if (idle_s) begin
         cur_addr_s    = desc_base;
         cur_row_s     = desc_base;
         cur_in_s      = CNT_ZERO;
         cur_out_s     = CNT_ZERO;
         cur_icnt_s    = desc_inner_cnt;
         cur_ocnt_s    = desc_outer_cnt;
         cur_istride_s = desc_inner_stride;
         cur_ostride_s = desc_outer_stride;
      end else begin
         cur_addr_s    = addr_r;
         cur_row_s     = row_r;
         cur_in_s      = in_r;
         cur_out_s     = out_r;
         cur_icnt_s    = icnt_r;
         cur_ocnt_s    = ocnt_r;
         cur_istride_s = istride_r;
         cur_ostride_s = ostride_r;
      end
      accept_s  = idle_s & start & ~abort;
      zero_s    = (desc_inner_cnt == CNT_ZERO) | (desc_outer_cnt == CNT_ZERO);
      fire_s    = issue_ready & ~abort & ((accept_s & ~zero_s) | (state_r == ST_ISSUE));
      end_row_s = (cur_in_s == cur_icnt_s - CNT_ONE);
      final_s   = end_row_s & (cur_out_s == cur_ocnt_s - CNT_ONE);

      sum_inner_s = SUM_W'(cur_addr_s) + SUM_W'(cur_istride_s);
      sum_outer_s = SUM_W'(cur_row_s) + SUM_W'(cur_ostride_s);
      if (end_row_s) begin
         row_n_s  = sum_outer_s[ADDR_WIDTH-1:0];
         addr_n_s = sum_outer_s[ADDR_WIDTH-1:0];
         in_n_s   = CNT_ZERO;
         out_n_s  = cur_out_s + CNT_ONE;
      end else begin
         row_n_s  = cur_row_s;
         addr_n_s = sum_inner_s[ADDR_WIDTH-1:0];
         in_n_s   = cur_in_s + CNT_ONE;
         out_n_s  = cur_out_s;
      end
`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
      carry_s = fire_s & ~final_s & (end_row_s ? sum_outer_s[ADDR_WIDTH] : sum_inner_s[ADDR_WIDTH]);
`endif

      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (zero_s) begin
                  state_s = ST_DONE;
               end else if (fire_s & final_s) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_ISSUE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (fire_s & final_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (pipe_valid_s & pipe_last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State, descriptor, walk counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         row_r       <= {ADDR_WIDTH{1'b0}};
         istride_r   <= {ADDR_WIDTH{1'b0}};
         ostride_r   <= {ADDR_WIDTH{1'b0}};
         bram_addr_r <= {ADDR_WIDTH{1'b0}};
         icnt_r      <= CNT_ZERO;
         ocnt_r      <= CNT_ZERO;
         in_r        <= CNT_ZERO;
         out_r       <= CNT_ZERO;
         bram_en_r   <= 1'b0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            icnt_r    <= desc_inner_cnt;
            ocnt_r    <= desc_outer_cnt;
            istride_r <= desc_inner_stride;
            ostride_r <= desc_outer_stride;
         end
         if (fire_s) begin
            addr_r      <= addr_n_s;
            row_r       <= row_n_s;
            in_r        <= in_n_s;
            out_r       <= out_n_s;
            bram_addr_r <= cur_addr_s;
         end else if (accept_s) begin
            addr_r <= desc_base;
            row_r  <= desc_base;
            in_r   <= CNT_ZERO;
            out_r  <= CNT_ZERO;
         end
         bram_en_r <= fire_s;
         last_r    <= fire_s & final_s;
         busy_r    <= (state_s != ST_IDLE);
         done_r    <= (state_s == ST_DONE);
      end
   end

   assign flush_s = abort & ~idle_s;

   fetch_valid_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_valid_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_s),
      .in_valid  (bram_en_r),
      .in_last   (last_r),
      .out_valid (pipe_valid_s),
      .out_last  (pipe_last_s)
   );

`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
   // Sticky overflow flag, rearmed by each accepted descriptor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (accept_s) begin
         err_r <= carry_s;
      end else begin
         err_r <= err_r | carry_s;
      end
   end
   assign addr_err = err_r;
`else
   assign addr_err = 1'b0;
`endif

   assign bram_en    = bram_en_r;
   assign bram_addr  = bram_addr_r;
   assign rd_valid   = pipe_valid_s;
   assign rd_last    = pipe_last_s;
   assign busy       = busy_r;
   assign fetch_done = done_r;

endmodule

// File: tb/tb_tile_fetch_agu.sv
// Self-checking bench for tile_fetch_agu: per-cycle expectations come from a
// nested-loop address list and an issue_ready schedule.
module tb_tile_fetch_agu;

   localparam int AW   = 16;
   localparam int CW   = 10;
   localparam int RDL  = 2;
   localparam int MAXC = 512;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, issue_ready;
   logic [AW-1:0] desc_base, desc_inner_stride, desc_outer_stride;
   logic [CW-1:0] desc_inner_cnt, desc_outer_cnt;
   logic          bram_en, rd_valid, rd_last, busy, fetch_done, addr_err;
   logic [AW-1:0] bram_addr;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   bit            exp_en[MAXC];
   logic [AW-1:0] exp_addr[MAXC];
   bit            exp_valid[MAXC], exp_last[MAXC], exp_done[MAXC], exp_busy[MAXC];
   bit            rdy[MAXC];
   logic [AW-1:0] addr_list[$];
   bit            exp_err;

   always #5 clk = ~clk;

   tile_fetch_agu #(
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW),
      .RD_LATENCY (RDL)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .abort             (abort),
      .desc_base         (desc_base),
      .desc_inner_cnt    (desc_inner_cnt),
      .desc_inner_stride (desc_inner_stride),
      .desc_outer_cnt    (desc_outer_cnt),
      .desc_outer_stride (desc_outer_stride),
      .issue_ready       (issue_ready),
      .bram_en           (bram_en),
      .bram_addr         (bram_addr),
      .rd_valid          (rd_valid),
      .rd_last           (rd_last),
      .busy              (busy),
      .fetch_done        (fetch_done),
      .addr_err          (addr_err)
   );

   // Reference tile walk: element (o,i) sits at base + o*ostride + i*istride
   task automatic build_list(input int base, input int icnt, input int istride,
                             input int ocnt, input int ostride);
      int a, rowm;
      addr_list.delete();
      exp_err = 1'b0;
      for (int o = 0; o < ocnt; o++) begin
         rowm = (base + o * ostride) & 32'hFFFF;
         for (int i = 0; i < icnt; i++) begin
            a = (base + o * ostride + i * istride) & 32'hFFFF;
            addr_list.push_back(AW'(a));
            if (i < icnt - 1) begin
               if (a + istride > 65535) exp_err = 1'b1;
            end else if (o < ocnt - 1) begin
               if (rowm + ostride > 65535) exp_err = 1'b1;
            end
         end
      end
   endtask

   task automatic run_fetch(input string name, input int base, input int icnt, input int istride,
                            input int ocnt, input int ostride, input int mode, input int tail,
                            output int done_obs);
      int n, k, last_c, done_c;
      bit err_req;
      build_list(base, icnt, istride, ocnt, ostride);
      n = icnt * ocnt;
      for (int c = 0; c < MAXC; c++) begin
         exp_en[c] = 1'b0; exp_addr[c] = '0; exp_valid[c] = 1'b0;
         exp_last[c] = 1'b0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0;
         case (mode)
            0:       rdy[c] = 1'b1;
            1:       rdy[c] = ($urandom_range(0, 3) != 0);
            default: rdy[c] = !(c >= 3 && c <= 5);
         endcase
      end
      k = 0;
      last_c = 0;
      for (int c = 0; c < MAXC - RDL - 2 && k < n; c++) begin
         if (rdy[c]) begin
            exp_en[c+1]         = 1'b1;
            exp_addr[c+1]       = addr_list[k];
            exp_valid[c+1+RDL]  = 1'b1;
            exp_last[c+1+RDL]   = (k == n - 1);
            if (k == n - 1) last_c = c + 1;
            k++;
         end
      end
      done_c = (n == 0) ? 1 : last_c + RDL + 1;
      exp_done[done_c] = 1'b1;
      for (int c = 1; c <= done_c; c++) exp_busy[c] = 1'b1;
      done_obs = -1;

      @(negedge clk);
      start             = 1'b1;
      desc_base         = AW'(base);
      desc_inner_cnt    = CW'(icnt);
      desc_inner_stride = AW'(istride);
      desc_outer_cnt    = CW'(ocnt);
      desc_outer_stride = AW'(ostride);
      issue_ready       = rdy[0];
      for (int c = 1; c <= done_c + tail; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk_cnt++;
         if (bram_en !== exp_en[c]) $display("FAIL %s cyc%0d bram_en got %0b exp %0b", name, c, bram_en, exp_en[c]);
         else pass_cnt++;
         if (exp_en[c]) begin
            chk_cnt++;
            if (bram_addr !== exp_addr[c]) $display("FAIL %s cyc%0d bram_addr got %h exp %h", name, c, bram_addr, exp_addr[c]);
            else pass_cnt++;
         end
         chk_cnt++;
         if (rd_valid !== exp_valid[c]) $display("FAIL %s cyc%0d rd_valid got %0b exp %0b", name, c, rd_valid, exp_valid[c]);
         else pass_cnt++;
         chk_cnt++;
         if (rd_last !== exp_last[c]) $display("FAIL %s cyc%0d rd_last got %0b exp %0b", name, c, rd_last, exp_last[c]);
         else pass_cnt++;
         chk_cnt++;
         if (fetch_done !== exp_done[c]) $display("FAIL %s cyc%0d fetch_done got %0b exp %0b", name, c, fetch_done, exp_done[c]);
         else pass_cnt++;
         chk_cnt++;
         if (busy !== exp_busy[c]) $display("FAIL %s cyc%0d busy got %0b exp %0b", name, c, busy, exp_busy[c]);
         else pass_cnt++;
         if (fetch_done === 1'b1 && done_obs < 0) done_obs = c;
         // A start and a fresh descriptor while busy must be ignored
         start             = (c == 2 && done_c >= 3);
         desc_base         = AW'($urandom);
         desc_inner_cnt    = CW'($urandom_range(0, 20));
         desc_inner_stride = AW'($urandom);
         desc_outer_cnt    = CW'($urandom_range(0, 20));
         desc_outer_stride = AW'($urandom);
         issue_ready       = rdy[c];
      end
      start = 1'b0;
`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
      err_req = exp_err;
`else
      err_req = 1'b0;
`endif
      chk_cnt++;
      if (addr_err !== err_req) $display("FAIL %s addr_err got %0b exp %0b", name, addr_err, err_req);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; issue_ready = 1'b0;
      desc_base = '0; desc_inner_cnt = '0; desc_inner_stride = '0;
      desc_outer_cnt = '0; desc_outer_stride = '0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({bram_en, bram_addr, rd_valid, rd_last, busy, fetch_done, addr_err} !== 22'd0)
         $display("FAIL reset outputs got %h exp 0", {bram_en, bram_addr, rd_valid, rd_last, busy, fetch_done, addr_err});
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if ({bram_en, busy, fetch_done, rd_valid} !== 4'd0)
         $display("FAIL reset_idle outputs got %b exp 0000", {bram_en, busy, fetch_done, rd_valid});
      else pass_cnt++;
   endtask

   task automatic test_linear();
      int d;
      run_fetch("linear", 64, 32, 1, 1, 0, 0, 2, d);
      chk_cnt++;
      if (d !== 32 + RDL + 1) $display("FAIL linear done_cycle got %0d exp %0d", d, 32 + RDL + 1);
      else pass_cnt++;
   endtask

   task automatic test_transpose();
      int d;
      run_fetch("transpose", 0, 4, 768, 3, 1, 0, 2, d);
   endtask

   task automatic test_back_pressure();
      int d0, d1;
      run_fetch("bp_ref", 200, 8, 1, 1, 0, 0, 2, d0);
      run_fetch("bp_stall", 200, 8, 1, 1, 0, 2, 2, d1);
      chk_cnt++;
      if (d1 - d0 !== 3) $display("FAIL back_pressure delay got %0d exp 3", d1 - d0);
      else pass_cnt++;
      run_fetch("bp_random", 17, 5, 3, 3, 40, 1, 2, d1);
   endtask

   task automatic test_zero_count();
      int d;
      run_fetch("zero_inner", 10, 0, 1, 4, 1, 0, 3, d);
      chk_cnt++;
      if (d !== 1) $display("FAIL zero_inner done_cycle got %0d exp 1", d);
      else pass_cnt++;
      run_fetch("zero_outer", 10, 4, 1, 0, 1, 0, 2, d);
   endtask

   task automatic test_abort();
      int d;
      bit seen;
      build_list(300, 16, 2, 1, 0);
      @(negedge clk);
      start = 1'b1; issue_ready = 1'b1;
      desc_base = AW'(300); desc_inner_cnt = CW'(16); desc_inner_stride = AW'(2);
      desc_outer_cnt = CW'(1); desc_outer_stride = '0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         chk_cnt++;
         if (bram_en !== 1'b1 || bram_addr !== addr_list[c-1])
            $display("FAIL abort_pre cyc%0d en/addr got %0b/%h exp 1/%h", c, bram_en, bram_addr, addr_list[c-1]);
         else pass_cnt++;
         chk_cnt++;
         if (rd_valid !== (c >= 1 + RDL)) $display("FAIL abort_pre cyc%0d rd_valid got %0b exp %0b", c, rd_valid, c >= 1 + RDL);
         else pass_cnt++;
      end
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL abort busy got %0b exp 0", busy);
      else pass_cnt++;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bram_en || rd_valid || fetch_done || busy) seen = 1'b1;
         @(negedge clk);
      end
      chk_cnt++;
      if (seen !== 1'b0) $display("FAIL abort_quiet activity got %0b exp 0", seen);
      else pass_cnt++;
      run_fetch("after_abort", 500, 6, 1, 2, 100, 0, 2, d);
   endtask

   task automatic test_bounds();
      int d;
      run_fetch("bounds_wrap", 16'hFFFE, 4, 1, 1, 0, 0, 2, d);
      chk_cnt++;
      if (addr_list[2] !== 16'h0000) $display("FAIL bounds_model third got %h exp 0000", addr_list[2]);
      else pass_cnt++;
      run_fetch("bounds_clear", 100, 3, 1, 2, 10, 0, 2, d);
   endtask

   task automatic test_back_to_back();
      int d;
      run_fetch("b2b_first", 1000, 3, 5, 2, 50, 0, 0, d);
      run_fetch("b2b_second", 2000, 2, 1, 2, 7, 0, 2, d);
   endtask

   task automatic test_random();
      int d, icnt, ocnt;
      for (int it = 0; it < 14; it++) begin
         icnt = (it == 6) ? 0 : $urandom_range(1, 8);
         ocnt = $urandom_range(1, 4);
         if (it < 7)
            run_fetch("random_small", $urandom_range(0, 4000), icnt, $urandom_range(0, 64),
                      ocnt, $urandom_range(0, 512), 1, $urandom_range(0, 2), d);
         else
            run_fetch("random_wide", $urandom_range(0, 65535), icnt, $urandom_range(0, 65535),
                      ocnt, $urandom_range(0, 65535), 1, $urandom_range(0, 2), d);
      end
   endtask

   initial begin
      test_reset();
      test_linear();
      test_transpose();
      test_back_pressure();
      test_zero_count();
      test_abort();
      test_bounds();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
